// File: rtl/fe_pow_if.sv
// fe_pow bus: request/result side plus the femul operand/product side.
// The slave modport is the sequencer's view; master is the environment's.
interface fe_pow_if #(
    parameter int EXP_BITS = 255
);
    logic                start;
    logic [254:0]        base;
    logic [EXP_BITS-1:0] exponent;
    logic                busy;
    logic                done;
    logic [254:0]        out;
    logic                mul_start;
    logic [254:0]        mul_a;
    logic [254:0]        mul_b;
    logic                mul_done;
    logic [254:0]        mul_out;

    modport slave (
        input  start, base, exponent, mul_done, mul_out,
        output busy, done, out, mul_start, mul_a, mul_b
    );

    modport master (
        output start, base, exponent, mul_done, mul_out,
        input  busy, done, out, mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/fe_pow.sv
// fe_pow: base^exponent mod 2^255-19 via left-to-right square-and-multiply.
// Every exponent bit is squared (no leading-one skip), so squares are data-independent.
module fe_pow #(
    parameter int EXP_BITS = 255
) (
    input  logic      clock,
    input  logic      reset_n,
    fe_pow_if.slave   bus
);
    localparam int IW = $clog2(EXP_BITS);
    localparam logic [IW-1:0] IDX_TOP = IW'(EXP_BITS - 1);
    localparam logic [254:0]  ONE     = 255'd1;

    typedef enum logic [2:0] {
        IDLE,
        SQ_START,
        SQ_WAIT,
        MUL_START,
        MUL_WAIT,
        FINISH
    } state_t;

    state_t              state_q;
    logic [254:0]        acc_q;
    logic [254:0]        base_q;
    logic [EXP_BITS-1:0] exp_q;
    logic [IW-1:0]       idx_q;
    logic                busy_q;
    logic                done_q;
    logic [254:0]        out_q;
    logic                mul_start_q;
    logic [254:0]        mul_b_q;

    // Operand a is always the accumulator; it only moves on a capture edge.
    assign bus.mul_a     = acc_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.mul_start = mul_start_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.out       = out_q;

    // Sequencer FSM; outputs are set on the edge entering the state that shows them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            base_q      <= '0;
            exp_q       <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_q       <= '0;
            mul_start_q <= 1'b0;
            mul_b_q     <= '0;
        end else begin
            mul_start_q <= 1'b0;
            done_q      <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        base_q      <= bus.base;
                        exp_q       <= bus.exponent;
                        acc_q       <= ONE;
                        idx_q       <= IDX_TOP;
                        busy_q      <= 1'b1;
                        mul_start_q <= 1'b1;
                        mul_b_q     <= ONE;
                        state_q     <= SQ_START;
                    end
                end
                SQ_START: begin
                    state_q <= SQ_WAIT;
                end
                SQ_WAIT: begin
                    if (bus.mul_done) begin
                        acc_q <= bus.mul_out;
                        if (exp_q[idx_q]) begin
                            mul_start_q <= 1'b1;
                            mul_b_q     <= base_q;
                            state_q     <= MUL_START;
                        end else if (idx_q == '0) begin
                            out_q   <= bus.mul_out;
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end else begin
                            idx_q       <= idx_q - 1'b1;
                            mul_start_q <= 1'b1;
                            mul_b_q     <= bus.mul_out;
                            state_q     <= SQ_START;
                        end
                    end
                end
                MUL_START: begin
                    state_q <= MUL_WAIT;
                end
                MUL_WAIT: begin
                    if (bus.mul_done) begin
                        acc_q <= bus.mul_out;
                        if (idx_q == '0) begin
                            out_q   <= bus.mul_out;
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end else begin
                            idx_q       <= idx_q - 1'b1;
                            mul_start_q <= 1'b1;
                            mul_b_q     <= bus.mul_out;
                            state_q     <= SQ_START;
                        end
                    end
                end
                FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fe_pow.sv
// Bench for fe_pow: behavioural femul with optional stalls, scoreboard on done.
// Reference exponentiation is right-to-left binary powering with wide arithmetic.
module tb_fe_pow;
    localparam int EB = 255;
    localparam logic [254:0] P = {255{1'b1}} - 255'd18;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    fe_pow_if #(.EXP_BITS(EB)) bus ();

    fe_pow #(.EXP_BITS(EB)) dut (
        .clock   (clock),
        .reset_n (rst_n),
        .bus     (bus.slave)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [254:0] act,
                       input logic [254:0] req);
        n_tot++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, req);
    endtask

    function automatic logic [254:0] mm(input logic [254:0] a,
                                        input logic [254:0] b);
        logic [511:0] t;
        logic [511:0] pw;
        pw = {257'd0, P};
        t  = {257'd0, a} * {257'd0, b};
        t  = t % pw;
        return t[254:0];
    endfunction

    function automatic logic [254:0] ref_pow(input logic [254:0] b,
                                             input logic [254:0] e);
        logic [254:0] r;
        logic [254:0] x;
        r = 255'd1;
        x = b;
        for (int i = 0; i < EB; i++) begin
            if (e[i]) r = mm(r, x);
            x = mm(x, x);
        end
        return r;
    endfunction

    function automatic logic [254:0] rnd255();
        logic [255:0] g;
        g = {$urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
        return g[254:0];
    endfunction

    // femul model: product after a delay, garbage on mul_out otherwise
    bit           stall = 1'b0;
    bit           pend  = 1'b0;
    int           rem   = 0;
    int           pulses = 0;
    int           stab_err = 0;
    int           ovl_err  = 0;
    logic [254:0] res, cap_a, cap_b;

    always @(negedge clock) begin
        bus.mul_done = 1'b0;
        bus.mul_out  = rnd255();
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (bus.mul_a !== cap_a || bus.mul_b !== cap_b) stab_err++;
                if (rem <= 1) begin
                    bus.mul_done = 1'b1;
                    bus.mul_out  = res;
                    pend = 1'b0;
                end else begin
                    rem--;
                end
            end
            if (bus.mul_start) begin
                pulses++;
                if (pend) ovl_err++;
                pend  = 1'b1;
                cap_a = bus.mul_a;
                cap_b = bus.mul_b;
                res   = mm(cap_a, cap_b);
                if (stall && $urandom_range(0, 3) == 0)
                    rem = int'($urandom_range(1, 20));
                else
                    rem = 1;
            end
        end
    end

    // scoreboard monitor
    logic [254:0] expq[$];
    logic [254:0] last_out = '0;
    int           dones = 0;

    always @(negedge clock) begin
        if (rst_n && bus.done) begin
            dones++;
            last_out = bus.out;
            if (expq.size() == 0) begin
                n_tot++;
                $display("FAIL unexpected_done: got %h want no done", bus.out);
            end else begin
                chk("result", bus.out, expq.pop_front());
            end
        end
    end

    task automatic issue(input logic [254:0] b, input logic [254:0] e);
        @(negedge clock); #1;
        bus.start    = 1'b1;
        bus.base     = b;
        bus.exponent = e;
        expq.push_back(ref_pow(b, e));
        @(negedge clock); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string nm);
        int c;
        c = 0;
        while (dones == d0 && c < 20000) begin
            @(negedge clock); #1;
            c++;
        end
        if (dones == d0) begin
            n_tot++;
            $display("FAIL %s_timeout: got no done want done", nm);
        end
    endtask

    task automatic run(input logic [254:0] b, input logic [254:0] e,
                       input string nm);
        int d0;
        d0 = dones;
        pulses = 0;
        issue(b, e);
        wait_done(d0, nm);
        chk({nm, "_pulses"}, 255'(pulses), 255'(EB + $countones(e)));
        chk({nm, "_busy_done_cycle"}, 255'(bus.busy), 255'd1);
        @(negedge clock); #1;
        chk({nm, "_busy_after"}, 255'(bus.busy), 255'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int d0;
        logic [254:0] e;
        bus.start    = 1'b0;
        bus.base     = '0;
        bus.exponent = '0;

        repeat (3) @(negedge clock);
        #1;
        chk("rst_busy", 255'(bus.busy), 255'd0);
        chk("rst_done", 255'(bus.done), 255'd0);
        chk("rst_mul_start", 255'(bus.mul_start), 255'd0);
        chk("rst_out", bus.out, 255'd0);
        chk("rst_mul_a", bus.mul_a, 255'd0);
        chk("rst_mul_b", bus.mul_b, 255'd0);
        @(negedge clock);
        rst_n = 1'b1;

        run(255'd2, 255'd10, "basic");
        chk("basic_out", last_out, 255'h400);
        run(255'd0, 255'd0, "zero_exp");
        chk("zero_exp_out", last_out, 255'd1);
        run(255'd1 << 128, 255'd2, "wrap");
        chk("wrap_out", last_out, 255'h26);
        run(255'd2, P - 255'd2, "inv");
        chk("inv_out", last_out, (P >> 1) + 255'd1);
        chk("inv_times2", mm(last_out, 255'd2), 255'd1);
        run(255'd1, rnd255(), "base_one");
        chk("base_one_out", last_out, 255'd1);
        run(255'd0, 255'd5, "base_zero");
        chk("base_zero_out", last_out, 255'd0);

        d0 = dones;
        issue(255'd7, 255'd12345);
        for (int k = 0; k < 4; k++) begin
            repeat (37) @(negedge clock);
            #1;
            bus.start = 1'b1;
            bus.base  = rnd255();
            bus.exponent = rnd255();
            @(negedge clock); #1;
            bus.start = 1'b0;
        end
        wait_done(d0, "busy_ignore");
        chk("busy_ignore_out", last_out, ref_pow(255'd7, 255'd12345));

        d0 = dones;
        bus.start    = 1'b1;
        bus.base     = 255'd5;
        bus.exponent = 255'd3;
        expq.push_back(ref_pow(255'd5, 255'd3));
        @(negedge clock); #1;
        @(negedge clock); #1;
        bus.start = 1'b0;
        wait_done(d0, "b2b");
        chk("b2b_out", last_out, 255'd125);

        issue(255'd9, 255'h1234);
        begin
            int c;
            c = 0;
            while (!(pulses >= 5 && pend) && c < 5000) begin
                @(negedge clock); #1;
                c++;
            end
        end
        @(posedge clock); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 255'(bus.busy), 255'd0);
        chk("mid_rst_out", bus.out, 255'd0);
        chk("mid_rst_mul_start", 255'(bus.mul_start), 255'd0);
        expq.delete();
        @(negedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        run(255'd3, 255'd5, "after_rst");
        chk("after_rst_out", last_out, 255'hf3);

        stall = 1'b1;
        for (int i = 0; i < 20; i++) begin
            logic [254:0] b;
            b = (i == 0) ? P + 255'd3 : rnd255();
            e = rnd255();
            run(b, e, "stall");
        end

        chk("operand_stability_errors", 255'(stab_err), 255'd0);
        chk("overlap_errors", 255'(ovl_err), 255'd0);
        chk("scoreboard_empty", 255'(expq.size()), 255'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
